// File: rtl/nubus_master.sv
// nubus_master: NuBus master-cycle sequencer (arbitrate, address phase, data phase, retry and timeout).
// Every output is a register updated together with the state, so there are no combinational input-to-output paths.
module nubus_master #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_valid,
   input  logic        cpu_masterd,
   input  logic        cpu_error,
   input  logic [3:0]  cpu_write,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   output logic [1:0]  cpu_status,
   input  logic [31:0] nub_ad_i,
   input  logic [1:0]  nub_tmn_i,
   input  logic        nub_ackn_i,
   input  logic        nub_grant_i,
   input  logic        nub_busy_i,
   output logic        mst_rqstn_o,
   output logic        mst_startn_o,
   output logic        mst_adrcyn_o,
   output logic        mst_ad_oe_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = MAX_RETRY < 1 ? 1 : $clog2(MAX_RETRY + 1);
   typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [RW-1:0] retry;
   logic          wr;
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         retry        <= '0;
         wr           <= 1'b0;
         cpu_ready    <= 1'b0;
         cpu_rdata    <= '0;
         cpu_status   <= 2'b00;
         mst_rqstn_o  <= 1'b1;
         mst_startn_o <= 1'b1;
         mst_adrcyn_o <= 1'b1;
         mst_ad_oe_o  <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         case (state)
            IDLE: if (cpu_valid && cpu_masterd) begin
               wr <= |cpu_write;
               if (cpu_error) begin
                  state      <= DONE;
                  cpu_ready  <= 1'b1;
                  cpu_status <= 2'b11;
               end else begin
                  state       <= REQ;
                  mst_rqstn_o <= 1'b0;
               end
            end
            REQ: if (nub_grant_i && !nub_busy_i) begin
               state        <= ADDR;
               cnt          <= '0;
               mst_rqstn_o  <= 1'b1;
               mst_startn_o <= 1'b0;
               mst_adrcyn_o <= 1'b0;
               mst_ad_oe_o  <= 1'b1;
            end
            ADDR: begin
               state        <= DATA;
               mst_startn_o <= 1'b1;
               mst_adrcyn_o <= 1'b1;
               mst_ad_oe_o  <= wr;
            end
            DATA: if (!nub_ackn_i) begin
               mst_ad_oe_o <= 1'b0;
               // tmn 00 is try-again-later; the status code is the inverted tmn for every terminal outcome
               if (nub_tmn_i == 2'b00 && retry < RW'(MAX_RETRY)) begin
                  retry       <= retry + 1'b1;
                  state       <= REQ;
                  mst_rqstn_o <= 1'b0;
               end else begin
                  state      <= DONE;
                  cpu_ready  <= 1'b1;
                  cpu_status <= ~nub_tmn_i;
                  if (nub_tmn_i == 2'b11 && !wr) cpu_rdata <= nub_ad_i;
               end
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state       <= DONE;
               mst_ad_oe_o <= 1'b0;
               cpu_ready   <= 1'b1;
               cpu_status  <= 2'b10;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               state <= IDLE;
               retry <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nubus_master.sv
// tb_nubus_master: builds per-transaction cycle scripts of stimulus and expected outputs, replays them against the DUT.
// Directed scenarios are pinned with literal cycle positions; random transactions exercise retries, timeouts and ignored inputs.
module tb_nubus_master;
   localparam int T = 8;
   localparam int MR = 3;
   typedef struct packed {
      logic        valid, masterd, error;
      logic [3:0]  write;
      logic        grant, busy, ackn;
      logic [1:0]  tmn;
      logic [31:0] ad;
   } stim_t;
   typedef struct packed {
      logic        rqstn, startn, adrcyn, oe, ready;
      logic [1:0]  status;
      logic [31:0] rdata;
   } exp_t;
   logic clk = 1'b0, reset = 1'b1;
   logic cpu_valid, cpu_masterd, cpu_error, cpu_ready;
   logic [3:0] cpu_write;
   logic [31:0] cpu_rdata, nub_ad_i;
   logic [1:0] cpu_status, nub_tmn_i;
   logic nub_ackn_i, nub_grant_i, nub_busy_i;
   logic mst_rqstn_o, mst_startn_o, mst_adrcyn_o, mst_ad_oe_o;
   int errors = 0, checks = 0;
   stim_t stim_q[$];
   exp_t exp_q[$], obs_q[$];
   logic [31:0] m_rdata = '0;
   always #5 clk = ~clk;
   nubus_master #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
      .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_masterd(cpu_masterd),
      .cpu_error(cpu_error), .cpu_write(cpu_write), .cpu_ready(cpu_ready),
      .cpu_rdata(cpu_rdata), .cpu_status(cpu_status), .nub_ad_i(nub_ad_i),
      .nub_tmn_i(nub_tmn_i), .nub_ackn_i(nub_ackn_i), .nub_grant_i(nub_grant_i),
      .nub_busy_i(nub_busy_i), .mst_rqstn_o(mst_rqstn_o), .mst_startn_o(mst_startn_o),
      .mst_adrcyn_o(mst_adrcyn_o), .mst_ad_oe_o(mst_ad_oe_o)
   );
   function automatic stim_t st_rand();
      stim_t s;
      s.valid = 1'($urandom); s.masterd = 1'($urandom); s.error = 1'($urandom);
      s.write = 4'($urandom); s.grant = 1'($urandom); s.busy = 1'($urandom);
      s.ackn = 1'($urandom); s.tmn = 2'($urandom); s.ad = $urandom;
      return s;
   endfunction
   function automatic exp_t ex_idle();
      exp_t e;
      e.rqstn = 1'b1; e.startn = 1'b1; e.adrcyn = 1'b1; e.oe = 1'b0; e.ready = 1'b0;
      e.status = 2'b00; e.rdata = m_rdata;
      return e;
   endfunction
   task automatic push(input stim_t s, input exp_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask
   task automatic done(input logic [1:0] st);
      stim_t s;
      exp_t e;
      s = st_rand(); s.valid = 1'b0;
      e = ex_idle(); e.ready = 1'b1; e.status = st;
      push(s, e);
   endtask
   task automatic gap(input int n);
      stim_t s;
      for (int i = 0; i < n; i++) begin
         s = st_rand(); s.masterd = 1'b0;
         push(s, ex_idle());
      end
   endtask
   // g: losing REQ cycles per attempt; ack: DATA cycle of the ack (-1 or >=T: none); tm: tmn at ack
   task automatic txn(input logic [3:0] wr, input bit err, input int g[4], input int ack[4],
                      input logic [1:0] tm[4], input logic [31:0] adv);
      stim_t s;
      exp_t e;
      int n;
      bit hit;
      s = st_rand(); s.valid = 1'b1; s.masterd = 1'b1; s.error = err; s.write = wr;
      push(s, ex_idle());
      if (err) begin
         done(2'b11);
         return;
      end
      for (int a = 0; a <= MR; a++) begin
         e = ex_idle(); e.rqstn = 1'b0;
         for (int k = 0; k < g[a]; k++) begin
            s = st_rand(); s.valid = 1'b1;
            if (s.grant) s.busy = 1'b1;
            push(s, e);
         end
         s = st_rand(); s.valid = 1'b1; s.grant = 1'b1; s.busy = 1'b0;
         push(s, e);
         e = ex_idle(); e.startn = 1'b0; e.adrcyn = 1'b0; e.oe = 1'b1;
         s = st_rand(); s.valid = 1'b1;
         push(s, e);
         hit = ack[a] >= 0 && ack[a] < T;
         n = hit ? ack[a] + 1 : T;
         e = ex_idle(); e.oe = |wr;
         for (int j = 0; j < n; j++) begin
            s = st_rand(); s.valid = 1'b1;
            s.ackn = !(hit && j == n - 1);
            if (hit && j == n - 1) begin
               s.tmn = tm[a];
               s.ad = adv;
            end
            push(s, e);
         end
         if (!hit) begin
            done(2'b10);
            return;
         end
         if (tm[a] != 2'b00 || a == MR) begin
            if (tm[a] == 2'b11 && wr == 4'b0000) m_rdata = adv;
            done(~tm[a]);
            return;
         end
      end
   endtask
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask
   function automatic int low_count(input int lo, input int hi, input bit start);
      int c = 0;
      for (int i = lo; i < hi && i < obs_q.size(); i++)
         c += start ? int'(!obs_q[i].startn) : int'(!obs_q[i].rqstn);
      return c;
   endfunction
   function automatic exp_t obs_at(input int i);
      exp_t e;
      e = '1;
      if (i < obs_q.size()) e = obs_q[i];
      return e;
   endfunction
   task automatic apply(input stim_t s);
      cpu_valid = s.valid; cpu_masterd = s.masterd; cpu_error = s.error; cpu_write = s.write;
      nub_grant_i = s.grant; nub_busy_i = s.busy; nub_ackn_i = s.ackn; nub_tmn_i = s.tmn;
      nub_ad_i = s.ad;
   endtask
   initial begin
      int ma, mb, mc, md, me, mf, mg;
      exp_t o, e;
      stim_t s;
      bit seen;
      s = st_rand(); s.valid = 1'b0;
      apply(s);
      ma = stim_q.size();
      txn(4'b0000, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{2'b11, 2'b11, 2'b11, 2'b11}, 32'hDEADBEEF);
      gap(2);
      mb = stim_q.size();
      txn(4'b1111, 0, '{5, 0, 0, 0}, '{1, 0, 0, 0}, '{2'b11, 2'b11, 2'b11, 2'b11}, 32'h12345678);
      mc = stim_q.size();
      txn(4'b0101, 1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{2'b11, 2'b11, 2'b11, 2'b11}, 32'h0);
      md = stim_q.size();
      txn(4'b0000, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{2'b00, 2'b00, 2'b00, 2'b00}, 32'h11111111);
      me = stim_q.size();
      txn(4'b0000, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{2'b00, 2'b00, 2'b11, 2'b11}, 32'hA5A5A5A5);
      mf = stim_q.size();
      txn(4'b0000, 0, '{0, 0, 0, 0}, '{-1, 0, 0, 0}, '{2'b11, 2'b11, 2'b11, 2'b11}, 32'h22222222);
      mg = stim_q.size();
      txn(4'b0000, 0, '{0, 0, 0, 0}, '{T - 1, 0, 0, 0}, '{2'b11, 2'b11, 2'b11, 2'b11}, 32'h0BADF00D);
      for (int r = 0; r < 40; r++) begin
         int g[4], ack[4];
         logic [1:0] tm[4];
         for (int a = 0; a < 4; a++) begin
            g[a] = $urandom_range(0, 3);
            ack[a] = $urandom_range(0, T + 1);
            tm[a] = 2'($urandom);
         end
         txn(($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom), $urandom_range(0, 9) == 0,
             g, ack, tm, $urandom);
         gap($urandom_range(0, 2));
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rqstn", 32'(mst_rqstn_o), 1);
      chk("reset_startn", 32'(mst_startn_o), 1);
      chk("reset_adrcyn", 32'(mst_adrcyn_o), 1);
      chk("reset_oe_ready", {mst_ad_oe_o, cpu_ready}, 0);
      chk("reset_rdata_status", cpu_rdata ^ 32'(cpu_status), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      foreach (stim_q[t]) begin
         apply(stim_q[t]);
         @(negedge clk);
         o = {mst_rqstn_o, mst_startn_o, mst_adrcyn_o, mst_ad_oe_o, cpu_ready, cpu_status, cpu_rdata};
         obs_q.push_back(o);
         e = exp_q[t];
         checks++;
         if (o.rqstn !== e.rqstn || o.startn !== e.startn || o.adrcyn !== e.adrcyn ||
             o.oe !== e.oe || o.ready !== e.ready || o.rdata !== e.rdata ||
             (e.ready && o.status !== e.status)) begin
            errors++;
            $display("FAIL cycle %0d got=%h want=%h", t, o, e);
         end
         @(posedge clk);
         #1;
      end
      chk("A_ready_at_4", 32'(obs_at(ma + 4).ready), 1);
      chk("A_not_ready_3", 32'(obs_at(ma + 3).ready), 0);
      chk("A_rdata", obs_at(ma + 4).rdata, 32'hDEADBEEF);
      chk("A_status", 32'(obs_at(ma + 4).status), 0);
      chk("A_oe_in_data", 32'(obs_at(ma + 3).oe), 0);
      chk("A_one_start", low_count(ma, ma + 5, 1), 1);
      chk("B_rqst_6", low_count(mb, mb + 11, 0), 6);
      chk("B_start_after_busy", 32'(obs_at(mb + 7).startn), 0);
      chk("B_oe_data", 32'({obs_at(mb + 8).oe, obs_at(mb + 9).oe}), 3);
      chk("B_done", 32'({obs_at(mb + 10).ready, obs_at(mb + 10).status}), 32'b100);
      chk("C_done", 32'({obs_at(mc + 1).ready, obs_at(mc + 1).status}), 32'b111);
      chk("C_no_rqst", low_count(mc, mc + 2, 0) + low_count(mc, mc + 2, 1), 0);
      chk("D_four_starts", low_count(md, me, 1), 4);
      chk("D_done", 32'({obs_at(md + 13).ready, obs_at(md + 13).status}), 32'b111);
      chk("E_done", 32'({obs_at(me + 10).ready, obs_at(me + 10).status}), 32'b100);
      chk("F_not_early", 32'(obs_at(mf + 10).ready), 0);
      chk("F_timeout", 32'({obs_at(mf + 11).ready, obs_at(mf + 11).status}), 32'b110);
      chk("G_ack_wins", 32'({obs_at(mg + 11).ready, obs_at(mg + 11).status}), 32'b100);
      chk("G_rdata", obs_at(mg + 11).rdata, 32'h0BADF00D);
      s = st_rand(); s.valid = 1'b1; s.masterd = 1'b1; s.error = 1'b0; s.write = 4'b0000;
      s.grant = 1'b1; s.busy = 1'b0; s.ackn = 1'b1;
      apply(s);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      cpu_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_strobes", 32'({mst_rqstn_o, mst_startn_o, mst_adrcyn_o}), 7);
      chk("rst_mid_oe_ready", 32'({mst_ad_oe_o, cpu_ready}), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_no_ready", 32'(cpu_ready), 0);
      @(posedge clk);
      #1 cpu_valid = 1'b1; nub_ackn_i = 1'b0; nub_tmn_i = 2'b11; nub_ad_i = 32'hCAFEF00D;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (cpu_ready) seen = 1'b1;
      end
      chk("post_rst_ready", 32'(seen), 1);
      chk("post_rst_rdata", cpu_rdata, 32'hCAFEF00D);
      chk("post_rst_status", 32'(cpu_status), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
